// File: rtl/ysyx_25020037_fetch_stage_pkg.sv
// Shared fetch-stage definitions: FSM state encoding and reset/NOP constants,
// imported by the fetch stage, the IDU and the core top level.
package ysyx_25020037_fetch_stage_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_OUT  = 2'd2
    } fetch_state_e;

    localparam logic [31:0] FETCH_RESET_PC = 32'h8000_0000;
    localparam logic [31:0] FETCH_NOP_INST = 32'h0000_0013;  // addi x0,x0,0

    function automatic logic word_aligned(input logic [31:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/ysyx_25020037_fetch_stage.sv
// Multi-cycle instruction fetch: one outstanding word read at a time, result
// handed to the decoder on valid/ready, redirects discard in-flight fetches.
//
// state  | meaning
// S_REQ  | presenting pc to imem (or raising a misalignment fault)
// S_WAIT | request accepted, waiting for the read response
// S_OUT  | {inst, pc, fault} held for the decoder until out_ready
module ysyx_25020037_fetch_stage
    import ysyx_25020037_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = FETCH_RESET_PC,
    parameter logic [31:0] NOP_INST = FETCH_NOP_INST
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        imem_resp_err,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic        out_fault,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] fetch_count
);

    fetch_state_e state;
    logic [31:0]  pc;
    logic         drop;
    logic         req_fire;

    // Valids are gated by rst so nothing is offered to the bus or decoder in reset.
    assign imem_req_valid = rst && (state == S_REQ) && word_aligned(pc);
    assign out_valid      = rst && (state == S_OUT);
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_REQ;
            pc          <= RESET_PC;
            drop        <= 1'b0;
            out_inst    <= NOP_INST;
            out_pc      <= RESET_PC;
            out_fault   <= 1'b0;
            fetch_count <= 32'd0;
        end else begin
            case (state)
                S_REQ: begin
                    if (redirect_valid) begin
                        pc <= redirect_pc;
                        if (req_fire) begin
                            drop  <= 1'b1;
                            state <= S_WAIT;
                        end
                    end else if (!word_aligned(pc)) begin
                        out_inst  <= NOP_INST;
                        out_pc    <= pc;
                        out_fault <= 1'b1;
                        state     <= S_OUT;
                    end else if (imem_req_ready) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (redirect_valid) begin
                        pc <= redirect_pc;
                        if (imem_resp_valid) begin
                            drop  <= 1'b0;
                            state <= S_REQ;
                        end else begin
                            drop <= 1'b1;
                        end
                    end else if (imem_resp_valid) begin
                        if (drop) begin
                            drop  <= 1'b0;
                            state <= S_REQ;
                        end else begin
                            out_inst  <= imem_resp_err ? NOP_INST : imem_resp_data;
                            out_fault <= imem_resp_err;
                            out_pc    <= pc;
                            state     <= S_OUT;
                        end
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        fetch_count <= fetch_count + 32'd1;
                        pc          <= redirect_valid ? redirect_pc : pc + 32'd4;
                        state       <= S_REQ;
                    end else if (redirect_valid) begin
                        pc    <= redirect_pc;
                        state <= S_REQ;
                    end
                end
                default: state <= S_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_25020037_fetch_stage.sv
// Self-checking bench for the fetch stage: directed scenarios followed by
// randomized memory/decoder/redirect traffic against a transaction-level model.
module tb_ysyx_25020037_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = 32'd0;
    logic        imem_resp_err = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        out_fault;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic [31:0] fetch_count;

    ysyx_25020037_fetch_stage dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .imem_resp_err   (imem_resp_err),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_inst        (out_inst),
        .out_pc          (out_pc),
        .out_fault       (out_fault),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .fetch_count     (fetch_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Transaction-level model: architectural pc, a read in flight (possibly
    // stale), and at most one instruction waiting for the decoder.
    logic [31:0] m_pc    = RST_PC;
    logic        m_outst = 1'b0;
    logic        m_stale = 1'b0;
    logic        m_pend  = 1'b0;
    logic [31:0] m_inst  = NOP;
    logic [31:0] m_ipc   = RST_PC;
    logic        m_fault = 1'b0;
    logic [31:0] m_count = 32'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = RST_PC; m_outst = 1'b0; m_stale = 1'b0; m_pend = 1'b0;
        m_inst = NOP; m_ipc = RST_PC; m_fault = 1'b0; m_count = 32'd0;
    endtask

    task automatic apply_reset(input int hold);
        @(negedge clk);
        rst = 1'b0;
        imem_req_ready = 1'b0; imem_resp_valid = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0;
        #1;
        model_reset();
        check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_req_addr", imem_req_addr, RST_PC);
        check("rst_out_inst", out_inst, NOP);
        check("rst_out_pc", out_pc, RST_PC);
        check("rst_out_fault", {31'd0, out_fault}, 32'd0);
        check("rst_fetch_count", fetch_count, 32'd0);
        repeat (hold) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic step(input logic rq_rdy, input logic o_rdy, input logic rd_v,
                        input logic [31:0] rd_pc, input logic rs_v,
                        input logic [31:0] rs_d, input logic rs_e);
        logic idle;
        @(negedge clk);
        imem_req_ready  = rq_rdy;
        out_ready       = o_rdy;
        redirect_valid  = rd_v;
        redirect_pc     = rd_pc;
        imem_resp_valid = rs_v;
        imem_resp_data  = rs_d;
        imem_resp_err   = rs_e;
        #1;
        idle = !m_outst && !m_pend;
        check("req_valid", {31'd0, imem_req_valid}, {31'd0, idle && (m_pc[1:0] == 2'b00)});
        check("req_addr", imem_req_addr, m_pc);
        check("out_valid", {31'd0, out_valid}, {31'd0, m_pend});
        if (m_pend) begin
            check("out_inst", out_inst, m_inst);
            check("out_pc", out_pc, m_ipc);
            check("out_fault", {31'd0, out_fault}, {31'd0, m_fault});
        end
        check("fetch_count", fetch_count, m_count);

        if (m_pend) begin
            if (o_rdy) begin
                m_count = m_count + 32'd1;
                m_pend  = 1'b0;
                m_pc    = rd_v ? rd_pc : m_ipc + 32'd4;
            end else if (rd_v) begin
                m_pend = 1'b0;
                m_pc   = rd_pc;
            end
        end else if (m_outst) begin
            if (rs_v) begin
                m_outst = 1'b0;
                if (!m_stale && !rd_v) begin
                    m_pend  = 1'b1;
                    m_inst  = rs_e ? NOP : rs_d;
                    m_fault = rs_e;
                    m_ipc   = m_pc;
                end
                m_stale = 1'b0;
            end else if (rd_v) begin
                m_stale = 1'b1;
            end
            if (rd_v) m_pc = rd_pc;
        end else begin
            if (rd_v) begin
                if (m_pc[1:0] == 2'b00 && rq_rdy) begin
                    m_outst = 1'b1;
                    m_stale = 1'b1;
                end
                m_pc = rd_pc;
            end else if (m_pc[1:0] != 2'b00) begin
                m_pend  = 1'b1;
                m_inst  = NOP;
                m_fault = 1'b1;
                m_ipc   = m_pc;
            end else if (rq_rdy) begin
                m_outst = 1'b1;
                m_stale = 1'b0;
            end
        end
    endtask

    initial begin
        logic        r_rdy, r_ordy, r_rdv, r_rsv, r_err;
        logic [31:0] r_rpc, r_data;

        apply_reset(2);

        // Zero-wait fetch of the first instruction.
        step(1, 1, 0, 0, 0, 0, 0);
        check("t1_first_addr", imem_req_addr, 32'h8000_0000);
        step(1, 1, 0, 0, 1, 32'h0010_0093, 0);
        step(1, 1, 0, 0, 0, 0, 0);
        check("t1_out_inst", out_inst, 32'h0010_0093);
        check("t1_out_pc", out_pc, 32'h8000_0000);

        // Decoder stall: held output, no new request, single pc advance.
        step(1, 1, 0, 0, 0, 0, 0);
        check("t1_next_addr", imem_req_addr, 32'h8000_0004);
        check("t1_count", fetch_count, 32'd1);
        step(1, 0, 0, 0, 1, 32'h0020_8133, 0);
        repeat (5) step(1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0);
        check("t2_stall_pc", out_pc, 32'h8000_0004);

        // Redirect while waiting: late response must be dropped.
        step(1, 1, 0, 0, 0, 0, 0);
        check("t2_advance_addr", imem_req_addr, 32'h8000_0008);
        step(1, 1, 1, 32'h8000_0100, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 1, 32'hDEAD_BEEF, 0);
        step(1, 1, 0, 0, 0, 0, 0);
        check("t3_redirect_addr", imem_req_addr, 32'h8000_0100);
        check("t3_no_out", {31'd0, out_valid}, 32'd0);

        // Bus error response becomes a NOP fault.
        step(1, 1, 0, 0, 1, 32'h1234_5678, 1);
        step(1, 1, 1, 32'h8000_0102, 0, 0, 0);
        check("t4_fault", {31'd0, out_fault}, 32'd1);
        check("t4_inst", out_inst, NOP);
        check("t4_pc", out_pc, 32'h8000_0100);

        // Misaligned redirect target: fault without a bus request.
        step(1, 1, 0, 0, 0, 0, 0);
        check("t5_no_req", {31'd0, imem_req_valid}, 32'd0);
        step(1, 1, 1, 32'h8000_0008, 0, 0, 0);
        check("t5_fault", {31'd0, out_fault}, 32'd1);
        check("t5_pc", out_pc, 32'h8000_0102);

        // Redirect coinciding with delivery.
        step(1, 1, 0, 0, 0, 0, 0);
        check("t6_addr", imem_req_addr, 32'h8000_0008);
        step(1, 1, 0, 0, 1, 32'h0020_0113, 0);
        step(1, 1, 1, 32'h8000_0200, 0, 0, 0);
        check("t6_inst", out_inst, 32'h0020_0113);
        step(1, 1, 0, 0, 0, 0, 0);
        check("t6_redirect_addr", imem_req_addr, 32'h8000_0200);
        check("t6_count", fetch_count, 32'd5);

        // Reset in the middle of a read; response after release is ignored.
        apply_reset(1);
        step(0, 1, 0, 0, 1, 32'hCAFE_F00D, 0);
        check("t7_addr", imem_req_addr, 32'h8000_0000);
        check("t7_no_out", {31'd0, out_valid}, 32'd0);
        step(1, 1, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 1, 32'h0030_0193, 0);
        step(1, 1, 0, 0, 0, 0, 0);
        check("t7_inst", out_inst, 32'h0030_0193);

        // Randomized traffic, including spurious responses and wrap-around targets.
        for (int i = 0; i < 4000; i++) begin
            r_rdy  = ($urandom_range(0, 3) != 0);
            r_ordy = ($urandom_range(0, 2) != 0);
            r_rdv  = ($urandom_range(0, 9) == 0);
            r_rpc  = 32'h8000_0000 | ($urandom & 32'h0000_0FFC);
            if ($urandom_range(0, 7) == 0) r_rpc[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 15) == 0) r_rpc = 32'hFFFF_FFF8;
            r_rsv  = m_outst ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
            r_data = $urandom;
            r_err  = ($urandom_range(0, 7) == 0);
            step(r_rdy, r_ordy, r_rdv, r_rpc, r_rsv, r_data, r_err);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
